updown_seg_counter: RTL and testbench

UPDOWN_SEG_COUNTER -- requirements
Module: updown_seg_counter

---
 rtl/updown_seg_counter.sv | 118 +++++++++++
 tb/tb_updown_seg_counter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/updown_seg_counter.sv
// Modulo-MOD up/down counter with load, terminal count, and a time-multiplexed
// seven-segment decimal display of the count (dp marks a downward last step).
module updown_seg_counter #(
    parameter int WIDTH    = 4,
    parameter int MOD      = 10,
    parameter int NDIG     = 2,
    parameter int SCAN_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             updown,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic [6:0]       seg,
    output logic             dp,
    output logic [NDIG-1:0]  digit
);

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int DW = (WIDTH > 4) ? WIDTH : 4;

    localparam logic [WIDTH-1:0] COUNT_MAX = WIDTH'(MOD - 1);
    localparam logic [SW-1:0]    SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0]    IDX_LAST  = IW'(NDIG - 1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             dir_q, dir_d;
    logic [SW-1:0]    scan_q, scan_d;
    logic [IW-1:0]    idx_q, idx_d;

    logic             din_in_range;
    logic [3:0]       dec [NDIG];
    logic [3:0]       dec_sel;

    function automatic logic [6:0] seg_pattern(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'b1111110;
            4'd1:    p = 7'b0110000;
            4'd2:    p = 7'b1101101;
            4'd3:    p = 7'b1111001;
            4'd4:    p = 7'b0110011;
            4'd5:    p = 7'b1011011;
            4'd6:    p = 7'b1011111;
            4'd7:    p = 7'b1110000;
            4'd8:    p = 7'b1111111;
            4'd9:    p = 7'b1111011;
            default: p = 7'b0000000;
        endcase
        return p;
    endfunction

    // One extra bit so MOD = 2^WIDTH compares correctly.
    assign din_in_range = ({1'b0, din} < (WIDTH+1)'(MOD));

    // NOTE: every always_comb output gets its default first so no path leaves it unassigned (no latch).
    always_comb begin
        count_d = count_q;
        dir_d   = dir_q;
        if (load) begin
            count_d = din_in_range ? din : COUNT_MAX;
        end else if (en) begin
            dir_d = updown;
            if (updown) begin
                count_d = (count_q == COUNT_MAX) ? '0 : count_q + WIDTH'(1);
            end else begin
                count_d = (count_q == '0) ? COUNT_MAX : count_q - WIDTH'(1);
            end
        end
    end

    always_comb begin
        scan_d = scan_q + SW'(1);
        idx_d  = idx_q;
        if (scan_q == SCAN_LAST) begin
            scan_d = '0;
            idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops sample the same pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            dir_q   <= 1'b1;
            scan_q  <= '0;
            idx_q   <= '0;
        end else begin
            count_q <= count_d;
            dir_q   <= dir_d;
            scan_q  <= scan_d;
            idx_q   <= idx_d;
        end
    end

    // Peel off decimal digits of the registered count, least significant first.
    always_comb begin
        logic [DW-1:0] rem;
        rem = DW'(count_q);
        for (int i = 0; i < NDIG; i++) begin
            dec[i] = 4'(rem % DW'(10));
            rem    = rem / DW'(10);
        end
    end

    assign dec_sel = dec[idx_q];
    assign out     = count_q;
    assign tc      = en & ~load & ((updown & (count_q == COUNT_MAX)) |
                                   (~updown & (count_q == '0)));
    assign seg     = seg_pattern(dec_sel);
    assign dp      = (idx_q == '0) & ~dir_q;
    assign digit   = NDIG'(1) << idx_q;

endmodule

// File: tb/tb_updown_seg_counter.sv
// Directed self-checking bench for updown_seg_counter at its default parameters.
module tb_updown_seg_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       updown;
    logic       load;
    logic [3:0] din;
    logic [3:0] out;
    logic       tc;
    logic [6:0] seg;
    logic       dp;
    logic [1:0] digit;

    int vectors = 0;
    int miscompares = 0;

    updown_seg_counter #(.WIDTH(4), .MOD(10), .NDIG(2), .SCAN_DIV(4)) dut (
        .clk(clk), .rst(rst), .en(en), .updown(updown), .load(load), .din(din),
        .out(out), .tc(tc), .seg(seg), .dp(dp), .digit(digit)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] pat(input int d);
        logic [6:0] table_v [10];
        table_v = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                    7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};
        return table_v[d];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #50;
        rst = 1'b1; en = 1'b1; load = 1'b1; din = 4'd5;
        #5;
        vectors++; if (out !== 4'd0) begin miscompares++; $display("FAIL rst_out got=%0d want=0", out); end
        vectors++; if (digit !== 2'b01) begin miscompares++; $display("FAIL rst_digit got=%b want=01", digit); end
        vectors++; if (seg !== 7'b1111110) begin miscompares++; $display("FAIL rst_seg got=%b want=1111110", seg); end
        vectors++; if (dp !== 1'b0) begin miscompares++; $display("FAIL rst_dp got=%b want=0", dp); end
        vectors++; if (tc !== 1'b0) begin miscompares++; $display("FAIL rst_tc_load got=%b want=0", tc); end
        load = 1'b0; updown = 1'b0;
        #1;
        vectors++; if (tc !== 1'b1) begin miscompares++; $display("FAIL rst_tc_down got=%b want=1", tc); end
        updown = 1'b1;
        #20;
        vectors++; if (out !== 4'd0) begin miscompares++; $display("FAIL rst_ignores_en got=%0d want=0", out); end
        vectors++; if (tc !== 1'b0) begin miscompares++; $display("FAIL rst_tc_up got=%b want=0", tc); end
        en = 1'b0;
        #43;
        rst = 1'b0;
        #1;
        vectors++; if (out !== 4'd0 || digit !== 2'b01 || seg !== 7'b1111110 || dp !== 1'b0) begin
            miscompares++;
            $display("FAIL post_rst got out=%0d digit=%b seg=%b dp=%b want 0/01/1111110/0", out, digit, seg, dp);
        end
        tick();
        vectors++; if (out !== 4'd0) begin miscompares++; $display("FAIL post_rst_hold got=%0d want=0", out); end
    endtask

    task automatic test_up_wrap();
        int exp_v;
        logic [6:0] exp_seg;
        en = 1'b1; updown = 1'b1; load = 1'b0;
        exp_v = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            exp_seg = (digit == 2'b10) ? pat(exp_v / 10) : pat(exp_v % 10);
            vectors++; if (out !== 4'(exp_v)) begin miscompares++; $display("FAIL up_out step=%0d got=%0d want=%0d", i, out, exp_v); end
            vectors++; if (tc !== (exp_v == 9)) begin miscompares++; $display("FAIL up_tc step=%0d got=%b want=%b", i, tc, exp_v == 9); end
            vectors++; if (seg !== exp_seg) begin miscompares++; $display("FAIL up_seg step=%0d got=%b want=%b", i, seg, exp_seg); end
            vectors++; if (dp !== 1'b0) begin miscompares++; $display("FAIL up_dp step=%0d got=%b want=0", i, dp); end
            tick();
            exp_v = (exp_v == 9) ? 0 : exp_v + 1;
        end
        vectors++; if (out !== 4'd0) begin miscompares++; $display("FAIL up_wrap_end got=%0d want=0", out); end
    endtask

    task automatic test_down_wrap();
        int exp_v;
        logic dir_e;
        en = 1'b1; updown = 1'b0; load = 1'b0;
        exp_v = 0;
        dir_e = 1'b1;
        for (int i = 0; i < 12; i++) begin
            #1;
            vectors++; if (out !== 4'(exp_v)) begin miscompares++; $display("FAIL down_out step=%0d got=%0d want=%0d", i, out, exp_v); end
            vectors++; if (tc !== (exp_v == 0)) begin miscompares++; $display("FAIL down_tc step=%0d got=%b want=%b", i, tc, exp_v == 0); end
            vectors++; if (dp !== (!dir_e && digit == 2'b01)) begin
                miscompares++; $display("FAIL down_dp step=%0d got=%b want=%b", i, dp, !dir_e && digit == 2'b01);
            end
            tick();
            dir_e = 1'b0;
            exp_v = (exp_v == 0) ? 9 : exp_v - 1;
        end
    endtask

    task automatic test_load();
        logic [3:0] din_v [7];
        int         exp_v [7];
        din_v = '{4'd7, 4'd12, 4'd9, 4'd10, 4'd15, 4'd0, 4'd3};
        exp_v = '{7, 9, 9, 9, 9, 0, 3};
        en = 1'b1; updown = 1'b1; load = 1'b1;
        for (int i = 0; i < 7; i++) begin
            din = din_v[i];
            #1;
            vectors++; if (tc !== 1'b0) begin miscompares++; $display("FAIL load_tc din=%0d got=%b want=0", din_v[i], tc); end
            tick();
            vectors++; if (out !== 4'(exp_v[i])) begin miscompares++; $display("FAIL load_out din=%0d got=%0d want=%0d", din_v[i], out, exp_v[i]); end
            vectors++; if (dp !== (digit == 2'b01)) begin miscompares++; $display("FAIL load_dir_held din=%0d got=%b want=%b", din_v[i], dp, digit == 2'b01); end
        end
        load = 1'b0; en = 1'b0;
    endtask

    task automatic test_scan();
        logic [1:0] prev_d;
        logic [1:0] exp_d;
        bit         found;
        load = 1'b1; din = 4'd9; en = 1'b0;
        tick();
        load = 1'b0;
        prev_d = digit;
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (digit !== prev_d) begin
                found = 1'b1;
                break;
            end
        end
        vectors++; if (!found) begin miscompares++; $display("FAIL scan_timeout got=no digit change want=change within 8 clocks"); end
        exp_d = (prev_d == 2'b01) ? 2'b10 : 2'b01;
        for (int i = 0; i < 12; i++) begin
            vectors++; if (digit !== exp_d) begin miscompares++; $display("FAIL scan_digit cyc=%0d got=%b want=%b", i, digit, exp_d); end
            vectors++; if (seg !== ((exp_d == 2'b01) ? pat(9) : pat(0))) begin
                miscompares++; $display("FAIL scan_seg cyc=%0d got=%b want=%b", i, seg, (exp_d == 2'b01) ? pat(9) : pat(0));
            end
            vectors++; if (dp !== (exp_d == 2'b01)) begin miscompares++; $display("FAIL scan_dp cyc=%0d got=%b want=%b", i, dp, exp_d == 2'b01); end
            tick();
            if (i % 4 == 3) exp_d = ~exp_d;
        end
    endtask

    task automatic test_hold();
        en = 1'b0; load = 1'b0;
        for (int i = 0; i < 20; i++) begin
            updown = ~updown;
            #1;
            vectors++; if (out !== 4'd9) begin miscompares++; $display("FAIL hold_out cyc=%0d got=%0d want=9", i, out); end
            vectors++; if (tc !== 1'b0) begin miscompares++; $display("FAIL hold_tc cyc=%0d got=%b want=0", i, tc); end
            vectors++; if (dp !== (digit == 2'b01)) begin miscompares++; $display("FAIL hold_dp cyc=%0d got=%b want=%b", i, dp, digit == 2'b01); end
            tick();
        end
    endtask

    task automatic test_mid_reset();
        en = 1'b1; updown = 1'b1; load = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        vectors++; if (out !== 4'd0 || digit !== 2'b01 || seg !== 7'b1111110 || dp !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_rst got out=%0d digit=%b seg=%b dp=%b want 0/01/1111110/0", out, digit, seg, dp);
        end
        #2;
        rst = 1'b0;
        tick();
        vectors++; if (out !== 4'd1) begin miscompares++; $display("FAIL mid_rst_resume got=%0d want=1", out); end
        en = 1'b0;
        for (int i = 2; i <= 4; i++) begin
            tick();
            vectors++; if (digit !== ((i == 4) ? 2'b10 : 2'b01)) begin
                miscompares++; $display("FAIL mid_rst_scan edge=%0d got=%b want=%b", i, digit, (i == 4) ? 2'b10 : 2'b01);
            end
        end
        vectors++; if (out !== 4'd1) begin miscompares++; $display("FAIL mid_rst_hold got=%0d want=1", out); end
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; load = 1'b0; updown = 1'b1; din = 4'd0;
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_load();
        test_scan();
        test_hold();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
